seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle 16-bit integer divider: one restoring-division quotient bit per clock.
//  Covers the divide operation the single-cycle ALU cannot; the execute stage issues it beside the ALU.
//  Handshake: start / busy / done. Signed or unsigned, selected by the same sign convention as the ALU.
// PARAMETERS
//  WIDTH    16  operand/result width; only 16 is verified
//  CNT_W     5  iteration counter width, must hold WIDTH
// PORTS
//  clk    in   1      single clock, all state on rising edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; accepted only when busy==0
//  A      in   WIDTH  dividend, sampled on the accepting edge
//  B      in   WIDTH  divisor, sampled on the accepting edge
//  sign   in   1      1 = two's-complement operands, 0 = unsigned
//  busy   out  1      high from the accepting edge until the DONE state is entered
//  done   out  1      one-cycle pulse; Quo/Rem/DivZ/Ofl valid
//  Quo    out  WIDTH  quotient, held until the next accepted start
//  Rem    out  WIDTH  remainder, held until the next accepted start
//  DivZ   out  1      divide by zero
//  Ofl    out  1      signed overflow (-32768 / -1)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, DivZ, Ofl = 0; Quo, Rem = 16'h0000; counter = 0.
//  Reset mid-RUN aborts the operation. No done is produced.
//  States:
//   - IDLE -start-> RUN | DONE (special cases).
//   - RUN -> RUN for 16 cycles, then -> DONE.
//   - DONE -> IDLE, or -> RUN/DONE if start is high.
//  Accept edge: latch |A| and |B| (magnitude only when sign=1), latch sign of A and sign of A^B, clear partial remainder and counter, set busy.
//  RUN step: P = {P[14:0], Q[15]}, Q <<= 1; D = P - |B|.
//   - If D >= 0: P = D, Q[0] = 1.
//   - Otherwise P is unchanged and Q[0] = 0.
//   - Counter increments; on count 15 the next state is DONE.
//  Latency: done asserts exactly 17 cycles after the accepting edge (16 RUN + 1 DONE).
//  Result sign fixup, registered on entry to DONE (sign=1 only):
//   - Quo is negated if sign(A) ^ sign(B).
//   - Rem is negated if sign(A).
//   - Result: Rem has the sign of the dividend; |Rem| < |B|.
//  Special cases, 1-cycle path (done on the cycle after the accepting edge):
//   - B == 0: Quo = 16'hFFFF, Rem = A, DivZ = 1.
//   - sign=1, A == 16'h8000, B == 16'hFFFF: Quo = 16'h8000, Rem = 0, Ofl = 1.
//  DivZ and Ofl are cleared on every accepted start.
//  start while busy=1: ignored; no queuing; A and B are not resampled.
//  start during DONE: accepted (back-to-back). done and the new busy may coincide for that one cycle.
//  Unsigned mode: |X| = X. Sign inputs are ignored. A=16'h8000 is treated as 32768.
// STRUCTURE
//  Shared include (div_defs.vh): state codes IDLE=2'd0, RUN=2'd1, DONE=2'd2; WIDTH; DIV_ITER=16.
//  The trial subtract P - |B| reuses carry_lookahead_16bit: (P, ~|B|, cin=1). Carry-out=1 means D >= 0.
//  No further sub-modules. FSM, counter, and P/Q registers stay in this file.
// TESTING
//  1. unsigned A=100, B=7 -> done 17 cycles after start; Quo=14, Rem=2; DivZ=0, Ofl=0.
//  2. signed A=-7 (16'hFFF9), B=2 -> Quo=16'hFFFD (-3), Rem=16'hFFFF (-1).
//  3. B=0, A=16'h1234 -> done next cycle; Quo=16'hFFFF, Rem=16'h1234, DivZ=1.
//  4. signed A=16'h8000, B=16'hFFFF -> done next cycle; Quo=16'h8000, Rem=0, Ofl=1.
//  5. Pulse start again at cycle 5 of RUN with new A/B -> ignored; original result returned.
//     Then start held during DONE -> second op completes 17 cycles later.
//  6. Assert rst at RUN cycle 8 -> busy=0, Quo=Rem=0 immediately (async); no done pulse.
//     A new op after reset gives correct results.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state codes, sizing
// constants and the conditional two's-complement negate used for sign fixup.
package seq_divider_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DIV_CNT_W = 5;
  localparam int unsigned DIV_ITER  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] x,
                                                    input logic                 neg);
    return neg ? (~x + DIV_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/carry_lookahead_16bit.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups with a
// second-level group carry chain.
//   a, b  : addends
//   cin   : carry in
//   sum   : a + b + cin (low 16 bits)
//   cout  : carry out of bit 15
module carry_lookahead_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  bg;
  logic [3:0]  bp;
  logic [4:0]  bc;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, group carries, then per-bit carries inside each group.
  always_comb begin
    c     = '0;
    bg    = '0;
    bp    = '0;
    bc    = '0;
    bc[0] = cin;
    for (int k = 0; k < 4; k++) begin
      bg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      bp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      bc[k+1] = bg[k] | (bp[k] & bc[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = bc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
    end
    c[16] = bc[4];
  end

  assign sum  = p ^ c[15:0];
  assign cout = c[16];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request, accepted when not busy (also accepted in DONE)
//   A, B, sign   : dividend, divisor, 1 = two's-complement operands
//   busy         : operation in flight (RUN)
//   done         : one-cycle result-valid pulse
//   Quo, Rem     : quotient / remainder, held until the next result
//   DivZ, Ofl    : divide-by-zero, signed overflow (-32768 / -1)
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quo,
  output logic [WIDTH-1:0] Rem,
  output logic             DivZ,
  output logic             Ofl
);

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITER - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_q_q, neg_q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divz_q, divz_d;
  logic             ofl_q, ofl_d;

  logic             accept_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH-1:0] p_shift_c;
  logic [WIDTH-1:0] diff_c;
  logic             no_borrow_c;
  logic [WIDTH-1:0] p_step_c;
  logic [WIDTH-1:0] q_step_c;

  assign accept_c = start && (state_q != RUN);
  assign a_mag_c  = cond_neg(A, sign & A[WIDTH-1]);
  assign b_mag_c  = cond_neg(B, sign & B[WIDTH-1]);

  // P never reaches bit 15 before a shift (P < 2^i after step i), so nothing is lost.
  assign p_shift_c = {p_q[WIDTH-2:0], q_q[WIDTH-1]};

  // Trial subtract P - |B| as P + ~|B| + 1; carry-out means no borrow (D >= 0).
  carry_lookahead_16bit u_sub (
    .a    (p_shift_c),
    .b    (~dvs_q),
    .cin  (1'b1),
    .sum  (diff_c),
    .cout (no_borrow_c)
  );

  assign p_step_c = no_borrow_c ? diff_c : p_shift_c;
  assign q_step_c = {q_q[WIDTH-2:0], no_borrow_c};

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    divz_d  = divz_q;
    ofl_d   = ofl_q;
    neg_a_d = neg_a_q;
    neg_q_d = neg_q_q;

    case (state_q)
      RUN: begin
        p_d   = p_step_c;
        q_d   = q_step_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          quo_d   = cond_neg(q_step_c, neg_q_q);
          rem_d   = cond_neg(p_step_c, neg_a_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accept overrides the DONE -> IDLE return, giving back-to-back operation.
    if (accept_c) begin
      divz_d  = 1'b0;
      ofl_d   = 1'b0;
      neg_a_d = sign & A[WIDTH-1];
      neg_q_d = sign & (A[WIDTH-1] ^ B[WIDTH-1]);
      dvs_d   = b_mag_c;
      q_d     = a_mag_c;
      p_d     = '0;
      cnt_d   = '0;
      if (B == '0) begin
        state_d = DONE;
        quo_d   = ALL_ONES;
        rem_d   = A;
        divz_d  = 1'b1;
      end else if (sign && (A == MIN_NEG) && (B == ALL_ONES)) begin
        state_d = DONE;
        quo_d   = MIN_NEG;
        rem_d   = '0;
        ofl_d   = 1'b1;
      end else begin
        state_d = RUN;
      end
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      divz_q  <= 1'b0;
      ofl_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_q_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      divz_q  <= divz_d;
      ofl_q   <= ofl_d;
      neg_a_q <= neg_a_d;
      neg_q_q <= neg_q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Quo  = quo_q;
  assign Rem  = rem_q;
  assign DivZ = divz_q;
  assign Ofl  = ofl_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus hand-written sequences
// for start-while-busy, back-to-back start in DONE, and reset mid-operation.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sign;
  logic        busy;
  logic        done;
  logic [15:0] quo;
  logic [15:0] rem;
  logic        divz;
  logic        ofl;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .sign  (sign),
    .busy  (busy),
    .done  (done),
    .Quo   (quo),
    .Rem   (rem),
    .DivZ  (divz),
    .Ofl   (ofl)
  );

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] quo;
    logic [15:0] rem;
    logic        divz;
    logic        ofl;
    int          lat;   // cycles from the start cycle to the done cycle
  } vec_t;

  localparam int NVEC    = 17;
  localparam int MAX_CYC = 40;

  vec_t vecs[NVEC];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge: present a request for one accepting edge.
  task automatic issue(input logic s, input logic [15:0] av, input logic [15:0] bv);
    sign  = s;
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Bounded wait for done; cyc is the start-relative cycle at which done is seen.
  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!done && cyc < MAX_CYC) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int done_seen;

    vecs[0]  = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 17};
    vecs[1]  = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17};
    vecs[2]  = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1};
    vecs[3]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 1};
    vecs[4]  = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
    vecs[5]  = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 17};
    vecs[6]  = '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 17};
    vecs[7]  = '{1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 17};
    vecs[8]  = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 17};
    vecs[9]  = '{1'b1, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1, 1'b0, 1};
    vecs[10] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 17};
    vecs[11] = '{1'b0, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 1'b0, 17};
    vecs[12] = '{1'b0, 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 1'b0, 17};
    vecs[13] = '{1'b1, 16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 17};
    vecs[14] = '{1'b1, 16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 17};
    vecs[15] = '{1'b0, 16'd1000, 16'd33,   16'd30,   16'd10,   1'b0, 1'b0, 17};
    vecs[16] = '{1'b1, 16'd1000, 16'hFFDF, 16'hFFE2, 16'd10,   1'b0, 1'b0, 17};

    rst   = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();

    chk1 ("reset_busy", busy, 1'b0);
    chk1 ("reset_done", done, 1'b0);
    chk16("reset_quo",  quo,  16'h0000);
    chk16("reset_rem",  rem,  16'h0000);
    chk1 ("reset_divz", divz, 1'b0);
    chk1 ("reset_ofl",  ofl,  1'b0);
    rst = 1'b0;
    step();

    // Table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      chk1($sformatf("v%0d_busy", i), busy, vecs[i].lat != 1);
      wait_done(1, cyc);
      chk_int($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      chk16($sformatf("v%0d_quo", i),  quo,  vecs[i].quo);
      chk16($sformatf("v%0d_rem", i),  rem,  vecs[i].rem);
      chk1 ($sformatf("v%0d_divz", i), divz, vecs[i].divz);
      chk1 ($sformatf("v%0d_ofl", i),  ofl,  vecs[i].ofl);
      step();
      chk1($sformatf("v%0d_done_pulse", i), done, 1'b0);
      chk1($sformatf("v%0d_idle_busy", i),  busy, 1'b0);
    end

    // Start pulsed during RUN is ignored; original operands finish.
    issue(1'b0, 16'd100, 16'd7);
    repeat (4) step();
    sign  = 1'b0;
    a     = 16'd50;
    b     = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    chk1("ignore_busy", busy, 1'b1);
    wait_done(6, cyc);
    chk_int("ignore_latency", cyc, 17);
    chk16("ignore_quo", quo, 16'd14);
    chk16("ignore_rem", rem, 16'd2);

    // Start held during DONE is accepted back-to-back.
    sign  = 1'b0;
    a     = 16'd1000;
    b     = 16'd33;
    start = 1'b1;
    step();
    start = 1'b0;
    chk1("b2b_busy", busy, 1'b1);
    wait_done(1, cyc);
    chk_int("b2b_latency", cyc, 17);
    chk16("b2b_quo", quo, 16'd30);
    chk16("b2b_rem", rem, 16'd10);
    step();

    // Asynchronous reset during RUN aborts without a done pulse.
    issue(1'b0, 16'd100, 16'd7);
    repeat (7) step();
    #2 rst = 1'b1;
    #1;
    chk1 ("abort_busy", busy, 1'b0);
    chk16("abort_quo",  quo,  16'h0000);
    chk16("abort_rem",  rem,  16'h0000);
    step();
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) done_seen++;
    end
    chk_int("abort_no_done", done_seen, 0);

    issue(1'b0, 16'h1234, 16'h0010);
    wait_done(1, cyc);
    chk_int("post_reset_latency", cyc, 17);
    chk16("post_reset_quo", quo, 16'h0123);
    chk16("post_reset_rem", rem, 16'h0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
